// File: rtl/mips_pkg.sv
// Shared multiply/divide definitions: operation codes, unit state and datapath widths.
package mips_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    // Codes 3'b110 and 3'b111 are accepted but do nothing.
    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: LSB-first shift-add multiply or restoring divide
// on a {high, low} accumulator pair.
module muldiv_step #(
    parameter int WIDTH = mips_pkg::WIDTH
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted_rem;
    logic             rem_ge;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum         = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
        shifted_rem = acc[2*WIDTH-1:WIDTH-1];
        rem_ge      = shifted_rem >= {1'b0, b};
        // Only consumed when rem_ge, so the true difference is below 2^WIDTH.
        diff        = shifted_rem[WIDTH-1:0] - b;
        if (is_div)
            acc_next = rem_ge ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
        else
            acc_next = {sum, acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning HI/LO.
// Optional MULDIV_FAST_MULT_EN: MULT/MULTU complete in one cycle through a full multiplier.
module ex_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = mips_pkg::WIDTH,
    parameter int CNT_W = mips_pkg::CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Abort,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               neg_p_q, neg_p_d;   // product or quotient sign
    logic               neg_r_q, neg_r_d;   // remainder sign
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic               signed_op, is_div_op, iter_op;
    logic [WIDTH-1:0]   a_abs, b_abs, quo, rem;
    logic [2*WIDTH-1:0] step_out;
`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_mag, fast_prod;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .b        (b_q),
        .acc_next (step_out)
    );

    always_comb begin
        signed_op = (Op == MD_MULT) || (Op == MD_DIV);
        is_div_op = (Op == MD_DIV) || (Op == MD_DIVU);
`ifdef MULDIV_FAST_MULT_EN
        iter_op   = is_div_op;
`else
        iter_op   = is_div_op || (Op == MD_MULT) || (Op == MD_MULTU);
`endif
        a_abs     = (signed_op && A[WIDTH-1]) ? -A : A;
        b_abs     = (signed_op && B[WIDTH-1]) ? -B : B;
        quo       = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];
`ifdef MULDIV_FAST_MULT_EN
        fast_mag  = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
        fast_prod = (signed_op && (A[WIDTH-1] ^ B[WIDTH-1])) ? -fast_mag : fast_mag;
`endif

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        neg_p_d  = neg_p_q;
        neg_r_d  = neg_r_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        if (Abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (Start) begin
                    if (iter_op) begin
                        state_d  = RUN;
                        cnt_d    = '1;
                        acc_d    = {{WIDTH{1'b0}}, a_abs};
                        b_d      = b_abs;
                        is_div_d = is_div_op;
                        neg_p_d  = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r_d  = (Op == MD_DIV) && A[WIDTH-1];
                        div0_d   = is_div_op && (B == '0);
                    end else if (Op == MD_MTHI) begin
                        hi_d   = A;
                        done_d = 1'b1;
                    end else if (Op == MD_MTLO) begin
                        lo_d   = A;
                        done_d = 1'b1;
                    end
`ifdef MULDIV_FAST_MULT_EN
                    else if ((Op == MD_MULT) || (Op == MD_MULTU)) begin
                        {hi_d, lo_d} = fast_prod;
                        done_d       = 1'b1;
                    end
`endif
                end
                RUN: begin
                    acc_d = step_out;
                    if (cnt_q == '0) state_d = FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                FIX: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    dbz_d   = div0_q;
                    if (is_div_q) begin
                        // Divisor 0 leaves remainder = |A|; re-signing it restores A.
                        lo_d = div0_q ? '1 : (neg_p_q ? -quo : quo);
                        hi_d = neg_r_q ? -rem : rem;
                    end else begin
                        {hi_d, lo_d} = neg_p_q ? -acc_q : acc_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            neg_p_q  <= neg_p_d;
            neg_r_q  <= neg_r_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit against an arithmetic HI/LO model.
module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset, Start, Abort;
    logic [2:0]  Op;
    logic [31:0] A, B;
    logic        Busy, Done, DivByZero;
    logic [31:0] Hi, Lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mdl_hi = '0, mdl_lo = '0;

    ex_muldiv_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B), .Abort(Abort),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural effect of one operation on HI/LO, from plain arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output bit dbz);
        longint     sp;
        logic [63:0] up;
        int         sa, sb;
        dbz = 1'b0;
        sa = int'(a);
        sb = int'(b);
        case (op)
            3'd0: begin sp = longint'(sa) * longint'(sb); {mdl_hi, mdl_lo} = sp; end
            3'd1: begin up = {32'd0, a} * {32'd0, b}; {mdl_hi, mdl_lo} = up; end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    mdl_hi = a; mdl_lo = 32'hFFFF_FFFF; dbz = 1'b1;
                end else if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    mdl_lo = 32'h8000_0000; mdl_hi = 0;
                end else if (op == 3'd2) begin
                    mdl_lo = sa / sb; mdl_hi = sa % sb;
                end else begin
                    mdl_lo = a / b; mdl_hi = a % b;
                end
            end
            3'd4: mdl_hi = a;
            3'd5: mdl_lo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge where Done is seen (or after the bound).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
        bit iter, exp_done, exp_dbz, seen;
        int k, busy_cnt, limit;
        iter     = (op <= 3'd1) ? !FAST : (op <= 3'd3);
        exp_done = (op <= 3'd5);
        model(op, a, b, exp_dbz);
        limit = exp_done ? 60 : 3;
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0; A = $urandom; B = $urandom;
        seen = 0; busy_cnt = 0; k = 1;
        while (k <= limit) begin
            if (Busy) busy_cnt++;
            if (Done) begin seen = 1; break; end
            // Ignored request while busy: must not disturb HI/LO.
            if (poke && k == 5) begin Start = 1'b1; Op = 3'd4; A = $urandom; end
            else Start = 1'b0;
            @(negedge Clk);
            k++;
        end
        Start = 1'b0;
        chk($sformatf("done_lat op%0d", op), seen ? k : 0, exp_done ? (iter ? 34 : 1) : 0);
        chk($sformatf("busy_cycles op%0d", op), busy_cnt, iter ? 33 : 0);
        chk($sformatf("hi op%0d", op), Hi, mdl_hi);
        chk($sformatf("lo op%0d", op), Lo, mdl_lo);
        chk($sformatf("dbz op%0d", op), DivByZero, exp_dbz);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dn;
        logic [31:0] hold_hi, hold_lo;
        Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Op = '0; A = '0; B = '0;
        repeat (2) @(negedge Clk);
        Start = 1'b1; Op = 3'd4; A = 32'hDEAD_BEEF;   // reset must win over Start
        @(negedge Clk);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_dbz", DivByZero, 0);
        chk("rst_hilo", {Hi, Lo}, 64'h0);
        Reset = 1'b0; Start = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
        chk("mult_k", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_k", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("div_k", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'd100, 32'd0, 1'b0);
        chk("divu0_k", {Hi, Lo, 31'd0, DivByZero}, {32'd100, 32'hFFFF_FFFF, 32'd1});
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_k", {Hi, Lo}, 64'h0000_0000_8000_0000);
        run_op(3'd2, 32'h8000_0000, 32'd0, 1'b0);
        chk("div0_neg_k", {Hi, Lo}, 64'h8000_0000_FFFF_FFFF);
        run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
        chk("mthi_k", Hi, 32'h1234_5678);
        run_op(3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0);
        chk("mtlo_k", {Hi, Lo}, 64'h1234_5678_9ABC_DEF0);
        run_op(3'd6, 32'h5555_5555, 32'd7, 1'b0);

        for (int i = 0; i < 60; i++)
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));

        @(negedge Clk);
        chk("done_width", {Done, DivByZero}, 2'b00);

        // Abort mid-divide with a competing Start.
        hold_hi = Hi; hold_lo = Lo;
        Start = 1'b1; Op = 3'd3; A = 32'd12345; B = 32'd7;
        @(negedge Clk);
        Start = 1'b0;
        repeat (8) @(negedge Clk);
        Abort = 1'b1; Start = 1'b1; Op = 3'd4; A = 32'hCAFE_F00D;
        @(negedge Clk);
        Abort = 1'b0; Start = 1'b0;
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        chk("abort_hilo", {Hi, Lo}, {hold_hi, hold_lo});
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done || DivByZero) dn++;
        end
        chk("abort_no_done", dn, 0);
        chk("abort_hilo_late", {Hi, Lo}, {hold_hi, hold_lo});

        // Reset in the middle of a multiply.
        Start = 1'b1; Op = 3'd0; A = 32'h7; B = 32'h9;
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        chk("mid_busy", Busy, 1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("mid_rst", {Busy, Done, DivByZero, Hi, Lo}, 67'h0);
        mdl_hi = 0; mdl_lo = 0;
        run_op(3'd3, 32'd50, 32'd7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
